// File: rtl/decoder_seq.sv
// Registered W-to-2^W one-hot decoder with direct (handshake) and auto-scan modes.
// Optional: define DECODER_SCAN_ONCE_EN to stop the scan after one full pass (adds scan_done).
module decoder_seq #(
    parameter int W       = 3,
    parameter int DWELL_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [W-1:0]          code,
    input  logic [DWELL_W-1:0]    dwell,
    output logic [(1<<W)-1:0]     out,
    output logic                  out_valid,
    output logic [W-1:0]          cur_code,
    output logic                  busy
`ifdef DECODER_SCAN_ONCE_EN
    ,
    output logic                  scan_done
`endif
);

    localparam int OW = 1 << W;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [OW-1:0]        out_q, out_d;
    logic [W-1:0]         cur_code_q, cur_code_d;
    logic                 out_valid_q, out_valid_d;
    logic [DWELL_W-1:0]   cnt_q, cnt_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic                 accept;

`ifdef DECODER_SCAN_ONCE_EN
    localparam logic [W:0] N_CODES = (W+1)'(OW);
    logic [W:0]           visit_q, visit_d;
    logic                 scan_done_q, scan_done_d;
`endif

    function automatic logic [OW-1:0] onehot(input logic [W-1:0] c);
        onehot    = '0;
        onehot[c] = 1'b1;
    endfunction

    // Held low during reset so nothing is accepted while the flops are clearing.
    assign in_ready = en & ~rst & (state_q == IDLE);
    assign accept   = in_valid & in_ready;

    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves a value unassigned (no latch).
        state_d     = state_q;
        out_d       = out_q;
        cur_code_d  = cur_code_q;
        out_valid_d = 1'b0;
        cnt_d       = cnt_q;
        dwell_d     = dwell_q;
`ifdef DECODER_SCAN_ONCE_EN
        visit_d     = visit_q;
        scan_done_d = 1'b0;
`endif
        if (en) begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        out_d       = onehot(code);
                        cur_code_d  = code;
                        out_valid_d = 1'b1;
                        if (mode) begin
                            state_d = SCAN;
                            dwell_d = dwell;
                            cnt_d   = dwell;
`ifdef DECODER_SCAN_ONCE_EN
                            visit_d = (W+1)'(1);
`endif
                        end
                    end
                end
                SCAN: begin
                    // Leaving the scan wins over a step due in the same cycle.
                    if (!mode) begin
                        state_d = IDLE;
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - DWELL_W'(1);
`ifdef DECODER_SCAN_ONCE_EN
                    end else if (visit_q == N_CODES) begin
                        state_d     = IDLE;
                        scan_done_d = 1'b1;
`endif
                    end else begin
                        cur_code_d  = cur_code_q + W'(1);
                        out_d       = onehot(cur_code_q + W'(1));
                        out_valid_d = 1'b1;
                        cnt_d       = dwell_q;
`ifdef DECODER_SCAN_ONCE_EN
                        visit_d     = visit_q + (W+1)'(1);
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            out_q       <= '0;
            cur_code_q  <= '0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
            dwell_q     <= '0;
`ifdef DECODER_SCAN_ONCE_EN
            visit_q     <= '0;
            scan_done_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values together.
            state_q     <= state_d;
            out_q       <= out_d;
            cur_code_q  <= cur_code_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
            dwell_q     <= dwell_d;
`ifdef DECODER_SCAN_ONCE_EN
            visit_q     <= visit_d;
            scan_done_q <= scan_done_d;
`endif
        end
    end

    // Pulses are masked by en so a freeze never shows a stale strobe.
    assign out       = out_q;
    assign out_valid = out_valid_q & en;
    assign cur_code  = cur_code_q;
    assign busy      = (state_q == SCAN);
`ifdef DECODER_SCAN_ONCE_EN
    assign scan_done = scan_done_q & en;
`endif

endmodule

// File: tb/tb_decoder_seq.sv
// Self-checking bench for decoder_seq: randomized scenarios against an arithmetic reference model.
// Honours DECODER_SCAN_ONCE_EN to exercise the scan-once feature.
module tb_decoder_seq;

    localparam int W  = 3;
    localparam int DW = 4;
    localparam int OW = 1 << W;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          mode = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  code = '0;
    logic [DW-1:0] dwell = '0;
    logic          in_ready;
    logic [OW-1:0] out;
    logic          out_valid;
    logic [W-1:0]  cur_code;
    logic          busy;
`ifdef DECODER_SCAN_ONCE_EN
    logic          scan_done;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    decoder_seq #(.W(W), .DWELL_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .code      (code),
        .dwell     (dwell),
        .out       (out),
        .out_valid (out_valid),
        .cur_code  (cur_code),
        .busy      (busy)
`ifdef DECODER_SCAN_ONCE_EN
        ,
        .scan_done (scan_done)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [OW-1:0] onehot_ref(input int c);
        logic [OW-1:0] r;
        r = OW'(1) << (c % OW);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        en = 1'b1;
        #1 rst = 1'b1;
        #2;
        n_checks++; if (out !== '0) begin n_fail++; $display("FAIL reset_out: got %h expected 00", out); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (cur_code !== '0) begin n_fail++; $display("FAIL reset_cur_code: got %0d expected 0", cur_code); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
        n_checks++; if (out !== '0) begin n_fail++; $display("FAIL release_out: got %h expected 00", out); end
    endtask

    task automatic test_direct();
        int c;
        int prev;
        mode = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < OW; i++) begin
            code = W'(i);
            tick();
            n_checks++; if (out !== onehot_ref(i)) begin n_fail++; $display("FAIL direct_out code=%0d: got %h expected %h", i, out, onehot_ref(i)); end
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL direct_out_valid code=%0d: got %b expected 1", i, out_valid); end
            n_checks++; if (cur_code !== W'(i)) begin n_fail++; $display("FAIL direct_cur_code: got %0d expected %0d", cur_code, i); end
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL direct_in_ready: got %b expected 1", in_ready); end
        end
        prev = OW - 1;
        for (int i = 0; i < 12; i++) begin
            c = (i % 4 == 3) ? prev : int'($urandom_range(0, OW-1));
            code = W'(c);
            tick();
            n_checks++; if (out !== onehot_ref(c)) begin n_fail++; $display("FAIL b2b_out code=%0d: got %h expected %h", c, out, onehot_ref(c)); end
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_out_valid code=%0d: got %b expected 1", c, out_valid); end
            n_checks++; if (cur_code !== W'(c)) begin n_fail++; $display("FAIL b2b_cur_code: got %0d expected %0d", cur_code, c); end
            prev = c;
        end
        in_valid = 1'b0;
        tick();
        n_checks++; if (out !== onehot_ref(prev)) begin n_fail++; $display("FAIL direct_hold_out: got %h expected %h", out, onehot_ref(prev)); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL direct_hold_out_valid: got %b expected 0", out_valid); end
    endtask

    // Code visible k enabled cycles after the start edge is start + k/(dwell+1).
    task automatic test_scan(input int s, input int d, input int len);
        int exp_c;
        exp_c = s;
        mode = 1'b1;
        code = W'(s);
        dwell = DW'(d);
        in_valid = 1'b1;
        tick();
        for (int k = 0; k < len; k++) begin
            exp_c = (s + k / (d + 1)) % OW;
            n_checks++; if (out !== onehot_ref(exp_c)) begin n_fail++; $display("FAIL scan_out s=%0d d=%0d k=%0d: got %h expected %h", s, d, k, out, onehot_ref(exp_c)); end
            n_checks++; if (cur_code !== W'(exp_c)) begin n_fail++; $display("FAIL scan_cur_code k=%0d: got %0d expected %0d", k, cur_code, exp_c); end
            n_checks++; if (out_valid !== (k % (d + 1) == 0)) begin n_fail++; $display("FAIL scan_out_valid k=%0d: got %b expected %b", k, out_valid, (k % (d + 1) == 0)); end
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL scan_busy k=%0d: got %b expected 1", k, busy); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL scan_in_ready k=%0d: got %b expected 0", k, in_ready); end
            if (k < len - 1) begin
                in_valid = 1'($urandom_range(0, 1));
                code = W'($urandom_range(0, OW-1));
                tick();
            end
        end
        mode = 1'b0;
        tick();
        n_checks++; if (out !== onehot_ref(exp_c)) begin n_fail++; $display("FAIL exit_out: got %h expected %h", out, onehot_ref(exp_c)); end
        n_checks++; if (cur_code !== W'(exp_c)) begin n_fail++; $display("FAIL exit_cur_code: got %0d expected %0d", cur_code, exp_c); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL exit_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL exit_busy: got %b expected 0", busy); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL exit_in_ready: got %b expected 1", in_ready); end
`ifdef DECODER_SCAN_ONCE_EN
        n_checks++; if (scan_done !== 1'b0) begin n_fail++; $display("FAIL exit_scan_done: got %b expected 0", scan_done); end
`endif
        in_valid = 1'b0;
        tick();
        n_checks++; if (out !== onehot_ref(exp_c)) begin n_fail++; $display("FAIL idle_hold_out: got %h expected %h", out, onehot_ref(exp_c)); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_hold_out_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_enable();
        int s;
        int d;
        int k;
        int exp_c;
        bit en_prev;
        bit en_next;
        mode = 1'b0;
        in_valid = 1'b1;
        code = W'(3);
        tick();
        n_checks++; if (out !== 8'h08) begin n_fail++; $display("FAIL en_pre_out: got %h expected 08", out); end
        en = 1'b0;
        code = W'(5);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL en_off_out_valid_now: got %b expected 0", out_valid); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (out !== 8'h08) begin n_fail++; $display("FAIL en_off_out cyc=%0d: got %h expected 08", i, out); end
            n_checks++; if (cur_code !== W'(3)) begin n_fail++; $display("FAIL en_off_cur_code: got %0d expected 3", cur_code); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL en_off_in_ready: got %b expected 0", in_ready); end
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL en_off_out_valid: got %b expected 0", out_valid); end
        end
        en = 1'b1;
        tick();
        n_checks++; if (out !== 8'h20) begin n_fail++; $display("FAIL en_resume_out: got %h expected 20", out); end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL en_resume_out_valid: got %b expected 1", out_valid); end
        n_checks++; if (cur_code !== W'(5)) begin n_fail++; $display("FAIL en_resume_cur_code: got %0d expected 5", cur_code); end

        // Freeze and resume in the middle of a scan; k only advances on enabled edges.
        s = int'($urandom_range(0, OW-1));
        d = int'($urandom_range(1, 3));
        mode = 1'b1;
        code = W'(s);
        dwell = DW'(d);
        tick();
        in_valid = 1'b0;
        k = 0;
        en_prev = 1'b1;
        for (int i = 0; i < 14; i++) begin
            exp_c = (s + k / (d + 1)) % OW;
            n_checks++; if (out !== onehot_ref(exp_c)) begin n_fail++; $display("FAIL freeze_out i=%0d k=%0d: got %h expected %h", i, k, out, onehot_ref(exp_c)); end
            n_checks++; if (out_valid !== (en_prev && (k % (d + 1) == 0))) begin n_fail++; $display("FAIL freeze_out_valid i=%0d: got %b expected %b", i, out_valid, (en_prev && (k % (d + 1) == 0))); end
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL freeze_busy i=%0d: got %b expected 1", i, busy); end
            en_next = ($urandom_range(0, 3) != 0);
            en = en_next;
            if (en_next) k++;
            en_prev = en_next;
            tick();
        end
        en = 1'b1;
        mode = 1'b0;
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL freeze_exit_busy: got %b expected 0", busy); end
    endtask

    task automatic test_async_reset();
        mode = 1'b1;
        code = W'($urandom_range(0, OW-1));
        dwell = DW'(0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        n_checks++; if (out !== '0) begin n_fail++; $display("FAIL arst_out: got %h expected 00", out); end
        n_checks++; if (cur_code !== '0) begin n_fail++; $display("FAIL arst_cur_code: got %0d expected 0", cur_code); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy: got %b expected 0", busy); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL arst_in_ready: got %b expected 0", in_ready); end
        #1 rst = 1'b0;
        mode = 1'b0;
        code = W'(7);
        in_valid = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_release_in_ready: got %b expected 1", in_ready); end
        tick();
        n_checks++; if (out !== 8'h80) begin n_fail++; $display("FAIL arst_direct_out: got %h expected 80", out); end
        n_checks++; if (cur_code !== W'(7)) begin n_fail++; $display("FAIL arst_direct_cur_code: got %0d expected 7", cur_code); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_direct_busy: got %b expected 0", busy); end
        in_valid = 1'b0;
    endtask

`ifdef DECODER_SCAN_ONCE_EN
    task automatic test_scan_once(input int s, input int d);
        int total;
        int exp_c;
        int fin;
        total = OW * (d + 1);
        fin = (s + OW - 1) % OW;
        mode = 1'b1;
        code = W'(s);
        dwell = DW'(d);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < total; k++) begin
            exp_c = (s + k / (d + 1)) % OW;
            n_checks++; if (out !== onehot_ref(exp_c)) begin n_fail++; $display("FAIL once_out s=%0d d=%0d k=%0d: got %h expected %h", s, d, k, out, onehot_ref(exp_c)); end
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL once_busy k=%0d: got %b expected 1", k, busy); end
            n_checks++; if (scan_done !== 1'b0) begin n_fail++; $display("FAIL once_early_done k=%0d: got %b expected 0", k, scan_done); end
            tick();
        end
        n_checks++; if (scan_done !== 1'b1) begin n_fail++; $display("FAIL once_done: got %b expected 1", scan_done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL once_done_busy: got %b expected 0", busy); end
        n_checks++; if (out !== onehot_ref(fin)) begin n_fail++; $display("FAIL once_final_out: got %h expected %h", out, onehot_ref(fin)); end
        n_checks++; if (cur_code !== W'(fin)) begin n_fail++; $display("FAIL once_final_cur_code: got %0d expected %0d", cur_code, fin); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL once_final_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL once_final_in_ready: got %b expected 1", in_ready); end
        tick();
        n_checks++; if (scan_done !== 1'b0) begin n_fail++; $display("FAIL once_done_pulse_width: got %b expected 0", scan_done); end
        n_checks++; if (out !== onehot_ref(fin)) begin n_fail++; $display("FAIL once_hold_out: got %h expected %h", out, onehot_ref(fin)); end
        mode = 1'b0;
    endtask
`endif

    initial begin
        int d;
        int lim;
        test_reset();
        test_direct();
        test_scan(6, 1, 7);
        test_scan(0, 0, 5);
        for (int i = 0; i < 4; i++) begin
            d = int'($urandom_range(0, 3));
            lim = (OW * (d + 1) < 20) ? OW * (d + 1) : 20;
            test_scan(int'($urandom_range(0, OW-1)), d, int'($urandom_range(1, lim)));
        end
        test_enable();
        test_async_reset();
`ifdef DECODER_SCAN_ONCE_EN
        test_scan_once(2, 0);
        test_scan_once(int'($urandom_range(0, OW-1)), int'($urandom_range(0, 2)));
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decoder_seq.md
Name: decoder_seq

Overview:
- Parametrised, registered W-to-2^W one-hot decoder. It is the clocked successor to the team's combinational 3-to-8 decoder.
- Two modes:
  - Direct: decodes a code accepted through a valid/ready handshake.
  - Scan: walks the one-hot output through all codes automatically, with a programmable dwell time.
- Used for row/bank selects and LED/segment strobing.

Parameters:
- W, 3, code width; output width is 2^W (default 8).
- DWELL_W, 4, width of the dwell input and of the internal dwell counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  global enable; 0 freezes all state.
- mode  in  1  0 = direct, 1 = scan.
- in_valid  in  1  code/dwell present.
- in_ready  out  1  block can accept a code.
- code  in  W  binary code (direct target or scan start code).
- dwell  in  DWELL_W  scan hold count; each code is held for dwell+1 cycles.
- out  out  2^W  registered one-hot output.
- out_valid  out  1  one-cycle pulse when out changes to a new code.
- cur_code  out  W  binary code currently driven on out.
- busy  out  1  high while in SCAN state.

Behaviour:
- Reset (async, rst=1):
  - out=0, out_valid=0, cur_code=0, busy=0, in_ready=0 while rst=1.
  - FSM=IDLE, dwell counter=0.
  - in_ready rises combinationally after reset release when en=1.
- FSM states: IDLE, SCAN.
- in_ready = en & (state==IDLE).
- Accept = in_valid & in_ready. mode is sampled in the accept cycle.
- IDLE, accept with mode=0 (direct):
  - Next edge: out = 1<<code, cur_code = code, out_valid = 1 for one cycle.
  - Latency is 1 cycle. Back-to-back accepts are allowed, one per cycle.
  - out holds until the next accept or reset.
  - out_valid pulses on every accept, even if the code is unchanged.
- IDLE, accept with mode=1 (scan start):
  - Next edge: out = 1<<code, cur_code = code, out_valid = 1.
  - dwell is latched; dwell counter is loaded with dwell; state goes to SCAN; busy = 1.
- SCAN, each enabled cycle:
  - If counter != 0: decrement the counter.
  - Else: cur_code = cur_code+1 mod 2^W, out = one-hot of the new code, out_valid = 1, counter reloads from the latched dwell.
  - Wrap: code 2^W-1 steps to 0. out goes from MSB-only to LSB-only with no all-zero cycle.
  - dwell=0 advances every cycle, so out_valid stays high continuously.
- SCAN exit: mode=0 sampled in SCAN gives IDLE at the next edge.
  - out and cur_code hold their last value; no out_valid pulse is generated.
  - Leaving SCAN has priority over a step in that same cycle.
- SCAN ignores in_valid and code (in_ready=0).
- en=0: FSM, counter, out and cur_code are frozen; out_valid=0; in_ready=0. Resuming continues from exactly the frozen point.
- Reset asserted mid-scan: all outputs clear asynchronously, FSM=IDLE, the latched dwell is lost.
- Only one bit of out is ever set after the first accept; out=0 only between reset and the first accept.

Optional Feature:
- Macro: DECODER_SCAN_ONCE_EN.
- Defined:
  - Scan stops automatically after visiting 2^W codes, counted from the start code inclusive.
  - After the final code's dwell expires: FSM goes to IDLE, out holds the final code (start-1 mod 2^W), and the extra output scan_done (out, 1) pulses for one cycle.
  - Exit via mode=0 still works; scan_done stays 0 in that case.
- Undefined: scan runs until mode=0; the scan_done port does not exist.

Test Plan:
- Reset then direct mode, accept codes 0..7 one per cycle -> out = 0x01,0x02,0x04,...,0x80 one cycle after each accept; out_valid high 8 cycles; cur_code matches.
- Scan start code=6, dwell=1 -> out 0x40 for 2 cycles, 0x80 for 2 cycles, 0x01 for 2 cycles (wrap), then 0x02; out_valid pulses on each change; busy=1; in_ready=0.
- Scan dwell=0 from code=0, then mode=0 after 5 cycles -> out walks 0x01..0x10, then holds 0x10, state IDLE, in_ready=1, no extra out_valid.
- Direct accept code=3, then en=0 for 4 cycles with in_valid=1 code=5 -> out stays 0x08, in_ready=0, out_valid=0; after en=1, code 5 accepted -> out 0x20.
- Mid-scan async rst pulse between clock edges -> out=0, cur_code=0, busy=0 immediately; after release, direct accept code=7 -> out 0x80.
- DECODER_SCAN_ONCE_EN, start code=2, dwell=0 -> codes 2..7,0,1 in 8 cycles; scan_done pulse after code 1's cycle; out holds 0x02; FSM IDLE.
